pe_mac_collector: RTL and testbench
===================================

PE_MAC_COLLECTOR -- requirements
Module: pe_mac_collector

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, 100 MHz, all logic on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset; clock clk.
REQ-003 SHALL have ports: clr  in  1  synchronous clear of accumulation pipeline only (driven by controller rst_PE).
REQ-004 SHALL have ports: en  in  1  operand sample enable (driven by controller on_PE).
REQ-005 SHALL have ports: a, w  in  8 each  unsigned activation and weight operands.
REQ-006 SHALL have ports: cap  in  4  capture strobes {cap22,cap21,cap12,cap11} (bit0 = C11).
REQ-007 SHALL have ports: c11, c12, c21, c22  out  20 each  captured convolution results.
REQ-008 SHALL have ports: acc  out  20  live accumulator value.
REQ-009 SHALL have ports: valid  out  4  per-result written mask; done  out  1  one-cycle pulse; full  out  1  level; ovf  out  1  sticky saturation flag; cap_err  out  1  sticky late-capture flag.

Function
REQ-010 SHALL implement 2-stage pipeline: S1 registers prod = a*w (16-bit unsigned) and tag = cap; S2 registers acc = acc + prod.
REQ-011 SHALL sample a, w, cap only when en=1; when en=0, S1 SHALL load prod=0, tag=0, and the pipeline SHALL keep draining.
REQ-012 SHALL latency: operands sampled at edge E0 contribute to acc at edge E0+2.
REQ-013 SHALL saturate acc at 20'hFFFFF; any addition whose true sum exceeds this SHALL set ovf.
REQ-014 SHALL, when S1 tag bit k is 1 at edge E, write capture register k with the value acc takes at E (acc + prod, saturated), i.e. the cap strobe aligns with the operand beat it accompanies.
REQ-015 SHALL, when multiple tag bits are set simultaneously, write all selected registers with the same value.
REQ-016 SHALL, on clr=1, set S1 prod=0, tag=0, acc=0, and clear ovf at that edge; capture registers, valid, full, cap_err SHALL be unaffected.
REQ-017 SHALL, when clr and a capturing tag coincide at the same edge, compute the capture from pre-clear acc and prod, then clear.
REQ-018 SHALL set valid[k] on writing register k; valid bits SHALL clear only on rst.
REQ-019 SHALL implement FSM COLLECT -> FULL: transition at the edge where valid becomes 4'b1111; done SHALL pulse high for exactly that cycle; full=1 in FULL.
REQ-020 SHALL, in FULL, ignore all further captures (registers hold) and set cap_err on any nonzero tag reaching S2.
REQ-021 SHALL, in COLLECT, allow rewriting an already-valid register (last write wins), with no error.
REQ-022 SHALL leave FULL only via rst.

Reset
REQ-023 SHALL, on rst=1, clear prod, tag, acc, c11..c22, valid, ovf, cap_err, done, full to 0 and enter COLLECT; rst SHALL take priority over clr, en, cap.
REQ-024 SHALL, on rst mid-accumulation, discard in-flight S1/S2 data; the first operand after rst SHALL appear in acc two edges later.

Verification
REQ-025 SHALL pass: rst, en=1, a=1..9 with w=1 on 9 beats, then a=w=0 with cap=4'b0001 -> c11=45, valid=4'b0001, two edges after cap beat.
REQ-026 SHALL pass: four windows of 9 beats (a=255, w=255), each followed by cap beat then clr -> each of c11..c22=585225, done high one cycle after fourth capture, full=1, ovf=0.
REQ-027 SHALL pass: 17 beats a=w=255 without clr -> acc=20'hFFFFF, ovf=1; then clr -> acc=0, ovf=0.
REQ-028 SHALL pass: cap=4'b0001 and clr asserted same edge as tag reaches S2 with acc=100, prod=5 -> c11=105, acc=0.
REQ-029 SHALL pass: after full=1, cap=4'b0010 beat -> c12 unchanged, cap_err=1; rst -> all outputs 0, FSM in COLLECT.
REQ-030 SHALL pass: en=0 for 3 cycles mid-window with a=7, w=7 held -> acc unchanged across those cycles.

Source files
------------

// File: rtl/pe_mac_collector.sv
// pe_mac_collector: two-stage unsigned MAC feeding four capture registers.
// S1 holds the product and capture tag of the sampled beat; S2 accumulates
// with saturation and, when the tag is set, copies the new accumulator value
// into the selected result register(s). A small FSM signals when all four
// results have been collected.
module pe_mac_collector (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  a,
  input  logic [7:0]  w,
  input  logic [3:0]  cap,
  output logic [19:0] c11,
  output logic [19:0] c12,
  output logic [19:0] c21,
  output logic [19:0] c22,
  output logic [19:0] acc,
  output logic [3:0]  valid,
  output logic        done,
  output logic        full,
  output logic        ovf,
  output logic        cap_err
);

  localparam int DATA_W = 8;
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = 20;
  localparam int NCAP   = 4;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_FULL    = 1'b1
  } state_t;

  // Clamp a one-bit-wide sum back into the accumulator range.
  function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W:0] sum);
    if (sum[ACC_W]) begin
      return {ACC_W{1'b1}};
    end
    return sum[ACC_W-1:0];
  endfunction

  // True when the unclamped sum no longer fits the accumulator.
  function automatic logic sum_ovf(input logic [ACC_W:0] sum);
    return sum[ACC_W];
  endfunction

  logic [PROD_W-1:0] prod_q, prod_d;
  logic [NCAP-1:0]   tag_q, tag_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [ACC_W:0]    sum;
  logic [ACC_W-1:0]  acc_sat;

  logic [ACC_W-1:0]  cap_q [NCAP];
  logic [NCAP-1:0]   valid_q, valid_d;
  logic [NCAP-1:0]   cap_wr;
  logic              done_q, done_d;
  logic              cap_err_q, cap_err_d;
  state_t            state_q, state_d;

  // ---- S1: operand sampling ----
  // Idle or cleared beats load a zero product so the pipeline keeps draining.
  always_comb begin
    prod_d = '0;
    tag_d  = '0;
    if (!clr && en) begin
      prod_d = PROD_W'(a) * PROD_W'(w);
      tag_d  = cap;
    end
  end

  // S1 pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      tag_q  <= '0;
    end else begin
      prod_q <= prod_d;
      tag_q  <= tag_d;
    end
  end

  // ---- S2: accumulate with saturation ----
  // The saturated sum is what a capture sees, even when clr wipes acc at the
  // same edge, so a tag always captures the window it closes.
  always_comb begin
    sum     = {1'b0, acc_q} + (ACC_W + 1)'(prod_q);
    acc_sat = sat_acc(sum);
    acc_d   = clr ? '0 : acc_sat;
    ovf_d   = clr ? 1'b0 : (ovf_q | sum_ovf(sum));
  end

  // S2 accumulator and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  // Collection control: captures are accepted only while collecting; any tag
  // arriving once all four results are held is flagged as a late capture.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    cap_wr    = '0;
    done_d    = 1'b0;
    cap_err_d = cap_err_q;
    case (state_q)
      ST_COLLECT: begin
        cap_wr  = tag_q;
        valid_d = valid_q | tag_q;
        if (valid_d == {NCAP{1'b1}}) begin
          state_d = ST_FULL;
          done_d  = 1'b1;
        end
      end
      ST_FULL: begin
        if (tag_q != '0) begin
          cap_err_d = 1'b1;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  // Collection state, valid mask, done pulse and late-capture flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_COLLECT;
      valid_q   <= '0;
      done_q    <= 1'b0;
      cap_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      cap_err_q <= cap_err_d;
    end
  end

  // Result registers; several may be written with the same value at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCAP; k++) begin
        cap_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NCAP; k++) begin
        if (cap_wr[k]) begin
          cap_q[k] <= acc_sat;
        end
      end
    end
  end

  assign c11     = cap_q[0];
  assign c12     = cap_q[1];
  assign c21     = cap_q[2];
  assign c22     = cap_q[3];
  assign acc     = acc_q;
  assign valid   = valid_q;
  assign done    = done_q;
  assign full    = (state_q == ST_FULL);
  assign ovf     = ovf_q;
  assign cap_err = cap_err_q;

endmodule

// File: tb/tb_pe_mac_collector.sv
// Testbench for pe_mac_collector: directed scenarios plus randomized traffic,
// every cycle compared against a beat-level reference model.
module tb_pe_mac_collector;

  logic        clk = 1'b0;
  logic        rst, clr, en;
  logic [7:0]  a, w;
  logic [3:0]  cap;
  logic [19:0] c11, c12, c21, c22, acc;
  logic [3:0]  valid;
  logic        done, full, ovf, cap_err;

  always #5 clk = ~clk;

  pe_mac_collector dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .a(a), .w(w), .cap(cap),
    .c11(c11), .c12(c12), .c21(c21), .c22(c22), .acc(acc),
    .valid(valid), .done(done), .full(full), .ovf(ovf), .cap_err(cap_err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: a beat enters the pipe at one edge and is folded into
  // the accumulator at the next; results are plain integers.
  localparam int ACC_MAX = 20'hFFFFF;
  typedef struct { int prod; int tag; } beat_t;
  beat_t q[$];
  int    m_acc, m_c[4];
  bit    m_ovf, m_err, m_full, m_done;
  bit [3:0] m_valid;

  task automatic model_reset();
    beat_t z = '{0, 0};
    m_acc = 0; m_ovf = 0; m_err = 0; m_full = 0; m_done = 0; m_valid = 0;
    for (int k = 0; k < 4; k++) m_c[k] = 0;
    q.delete();
    q.push_back(z);
  endtask

  task automatic model_edge(input bit r, input bit c, input bit e,
                            input int av, input int wv, input int cv);
    beat_t b, nb;
    int s, nacc;
    if (r) begin
      model_reset();
      return;
    end
    b = q.pop_front();
    s = m_acc + b.prod;
    nacc = (s > ACC_MAX) ? ACC_MAX : s;
    m_done = 0;
    if (b.tag != 0) begin
      if (m_full) m_err = 1;
      else begin
        for (int k = 0; k < 4; k++)
          if (b.tag[k]) begin m_c[k] = nacc; m_valid[k] = 1; end
        if (m_valid == 4'hF) begin m_full = 1; m_done = 1; end
      end
    end
    m_acc = nacc;
    if (s > ACC_MAX) m_ovf = 1;
    nb = '{0, 0};
    if (c) begin
      m_acc = 0;
      m_ovf = 0;
    end else if (e) begin
      nb = '{av * wv, cv};
    end
    q.push_back(nb);
  endtask

  task automatic compare_all();
    chk("acc", acc, m_acc);
    chk("valid", valid, m_valid);
    chk("c11", c11, m_c[0]);
    chk("c12", c12, m_c[1]);
    chk("c21", c21, m_c[2]);
    chk("c22", c22, m_c[3]);
    chk("done", done, m_done);
    chk("full", full, m_full);
    chk("ovf", ovf, m_ovf);
    chk("cap_err", cap_err, m_err);
  endtask

  task automatic step(input bit r, input bit c, input bit e,
                      input int av, input int wv, input int cv);
    rst = r; clr = c; en = e; a = av[7:0]; w = wv[7:0]; cap = cv[3:0];
    @(posedge clk);
    model_edge(r, c, e, av, wv, cv);
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(0, 0, 1, 0, 0, 0);
  endtask

  initial begin
    rst = 1; clr = 0; en = 0; a = 0; w = 0; cap = 0;
    model_reset();

    // Reset state
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_acc", acc, 0);
    chk("rst_full", full, 0);
    chk("rst_valid", valid, 0);

    // Sum 1..9 captured into c11
    for (int i = 1; i <= 9; i++) step(0, 0, 1, i, 1, 0);
    step(0, 0, 1, 0, 0, 1);
    idle();
    idle();
    chk("sum9_c11", c11, 45);
    chk("sum9_valid", valid, 4'b0001);

    // Four full windows of 255*255, each captured then cleared
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 9; i++) step(0, 0, 1, 255, 255, 0);
      step(0, 0, 1, 0, 0, 1 << k);
      step(0, 1, 0, 0, 0, 0);
      if (k == 3) begin
        chk("win_done", done, 1);
        chk("win_full", full, 1);
      end
    end
    chk("win_c11", c11, 585225);
    chk("win_c22", c22, 585225);
    chk("win_ovf", ovf, 0);
    idle();
    chk("win_done_drop", done, 0);

    // Late capture after FULL
    step(0, 0, 1, 3, 3, 4'b0010);
    idle();
    chk("late_c12", c12, 585225);
    chk("late_err", cap_err, 1);
    step(1, 0, 0, 0, 0, 0);
    chk("late_rst_full", full, 0);
    chk("late_rst_err", cap_err, 0);
    chk("late_rst_c12", c12, 0);

    // Saturation, then clr
    for (int i = 0; i < 17; i++) step(0, 0, 1, 255, 255, 0);
    idle();
    chk("sat_acc", acc, 20'hFFFFF);
    chk("sat_ovf", ovf, 1);
    step(0, 1, 0, 0, 0, 0);
    chk("sat_clr_acc", acc, 0);
    chk("sat_clr_ovf", ovf, 0);

    // Capture coinciding with clr uses pre-clear value
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 10, 10, 0);
    step(0, 0, 1, 5, 1, 1);
    step(0, 1, 0, 0, 0, 0);
    chk("clrcap_c11", c11, 105);
    chk("clrcap_acc", acc, 0);

    // en low holds acc
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 7, 7, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 7, 7, 0);
      chk("hold_acc", acc, 147);
    end
    step(0, 0, 1, 7, 7, 0);
    step(0, 0, 1, 7, 7, 0);
    chk("resume_acc", acc, 196);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit r, c, e;
      int cv;
      r  = ($urandom_range(0, 99) == 0);
      c  = ($urandom_range(0, 19) == 0);
      e  = ($urandom_range(0, 3) != 0);
      cv = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 15)) : 0;
      step(r, c, e, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), cv);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
